// File: rtl/da_out_round_fifo.sv
// -----------------------------------------------------------------------------
// da_out_round_fifo
//
// Output stage for the distributed-arithmetic filter. It samples the divided
// byte clock on the bit clock and picks up each new 17-bit filter sum on the
// byte-clock rising edge. The sum is rounded half-up to an 8-bit sample and
// queued in a small ready/valid FIFO for the downstream consumer.
//
// Optional feature: define DA_OUT_SAT_EN to clamp the rounded value to the
// 8-bit signed range. When it is undefined the result wraps (two's complement)
// and no clamp logic is built.
//
// Parameters
//   DEPTH      FIFO depth in samples (power of two, 2..16)
//
// Ports
//   clk_bit    in   bit clock, the only clock of this block
//   rst_n      in   asynchronous active-low reset
//   clk_byte   in   divided byte clock, sampled as data on clk_bit
//   sum_in     in   signed filter sum {intsum[9:0], extra[6:0]}
//   y_out      out  signed rounded sample at the FIFO head (0 when empty)
//   y_valid    out  FIFO non-empty
//   y_ready    in   consumer accepts y_out when y_valid is also high
//   fifo_level out  current occupancy, 0..DEPTH
//   ovf        out  sticky: a sample was dropped because the FIFO was full
//   clr_ovf    in   synchronous clear of ovf (a same-cycle overflow wins)
// -----------------------------------------------------------------------------
module da_out_round_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_bit,
  input  logic                       rst_n,
  input  logic                       clk_byte,
  input  logic signed [16:0]         sum_in,
  output logic signed [7:0]          y_out,
  output logic                       y_valid,
  input  logic                       y_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       ovf,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);

  // Round half-up by 7 bits: add 64 in 18-bit signed space, keep bits [17:7].
  function automatic logic signed [10:0] round_q(input logic signed [16:0] s);
    return 11'((({s[16], s}) + 18'd64) >> 7);
  endfunction

  // Reduce the rounded value to the 8-bit output sample.
  function automatic logic signed [7:0] fmt_out(input logic signed [10:0] q);
`ifdef DA_OUT_SAT_EN
    if (q > 11'sd127)
      return 8'sh7F;
    else if (q < -11'sd128)
      return 8'sh80;
    else
      return 8'(q);
`else
    return 8'(q);
`endif
  endfunction

  logic                     r_byte_q;
  logic signed [16:0]       r_stage_p1;
  logic                     r_vld_p1;
  logic [AW:0]              r_wr_ptr;
  logic [AW:0]              r_rd_ptr;
  logic                     r_ovf;
  logic signed [7:0]        r_mem [DEPTH];

  logic                     w_detect;
  logic signed [10:0]       w_q;
  logic signed [7:0]        w_result;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_wr_en;
  logic                     w_drop;

  assign w_detect = clk_byte & ~r_byte_q;

  assign w_q      = round_q(r_stage_p1);
  assign w_result = fmt_out(w_q);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop    = ~w_empty & y_ready;
  // A same-cycle pop frees the head slot, so a push into a full FIFO is
  // still accepted in that case.
  assign w_wr_en  = r_vld_p1 & (~w_full | w_pop);
  assign w_drop   = r_vld_p1 & w_full & ~w_pop;

  // p0 -> p1: edge detect on the byte clock and capture of the filter sum.
  // byte_q resets high so a byte clock already high at reset release is not
  // mistaken for a rising edge.
  always_ff @(posedge clk_bit or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_q   <= 1'b1;
      r_stage_p1 <= '0;
      r_vld_p1   <= 1'b0;
    end else begin
      r_byte_q <= clk_byte;
      r_vld_p1 <= w_detect;
      if (w_detect)
        r_stage_p1 <= sum_in;
    end
  end

  // p1 -> FIFO: rounded sample is pushed, pointers and overflow updated.
  always_ff @(posedge clk_bit or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_en)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop)
        r_ovf <= 1'b1;
      else if (clr_ovf)
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk_bit) begin
    if (w_wr_en)
      r_mem[r_wr_ptr[AW-1:0]] <= w_result;
  end

  assign y_valid    = ~w_empty;
  // Gating with y_valid keeps y_out at zero while empty or in reset, so the
  // storage array itself needs no reset.
  assign y_out      = y_valid ? r_mem[r_rd_ptr[AW-1:0]] : 8'sd0;
  assign fifo_level = r_wr_ptr - r_rd_ptr;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_da_out_round_fifo.sv
module tb_da_out_round_fifo;

  logic        clk_bit;
  logic        rst_n;
  logic        clk_byte;
  logic [16:0] sum_in;
  logic [7:0]  y_out;
  logic        y_valid;
  logic        y_ready;
  logic [2:0]  fifo_level;
  logic        ovf;
  logic        clr_ovf;

  int n_chk;
  int n_fail;

  da_out_round_fifo #(.DEPTH(4)) dut (
    .clk_bit    (clk_bit),
    .rst_n      (rst_n),
    .clk_byte   (clk_byte),
    .sum_in     (sum_in),
    .y_out      (y_out),
    .y_valid    (y_valid),
    .y_ready    (y_ready),
    .fifo_level (fifo_level),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf)
  );

  initial begin
    clk_bit = 1'b0;
    forever #5 clk_bit = ~clk_bit;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise the byte clock with a new sum, return after the push edge.
  task automatic send_start(input logic [16:0] v);
    clk_byte = 1'b1;
    sum_in   = v;
    @(negedge clk_bit);
    @(negedge clk_bit);
  endtask

  // Complete the 8-cycle byte period started by send_start.
  task automatic send_end();
    @(negedge clk_bit);
    @(negedge clk_bit);
    clk_byte = 1'b0;
    repeat (4) @(negedge clk_bit);
  endtask

  task automatic send(input logic [16:0] v);
    send_start(v);
    send_end();
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clk_byte = 1'b0;
    sum_in   = '0;
    y_ready  = 1'b0;
    clr_ovf  = 1'b0;
    repeat (2) @(negedge clk_bit);

    chk("rst_valid", 17'(y_valid), 17'd0);
    chk("rst_level", 17'(fifo_level), 17'd0);
    chk("rst_ovf", 17'(ovf), 17'd0);
    chk("rst_yout", 17'(y_out), 17'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_bit);

    // Basic rounding and latency, consumer always ready.
    y_ready  = 1'b1;
    clk_byte = 1'b1;
    sum_in   = 17'h00080;
    @(negedge clk_bit);
    chk("lat1_valid_low", 17'(y_valid), 17'd0);
    @(negedge clk_bit);
    chk("lat2_valid_high", 17'(y_valid), 17'd1);
    chk("y_0x080", 17'(y_out), 17'h01);
    chk("lvl_one", 17'(fifo_level), 17'd1);
    @(negedge clk_bit);
    chk("popped_empty", 17'(y_valid), 17'd0);
    @(negedge clk_bit);
    clk_byte = 1'b0;
    repeat (4) @(negedge clk_bit);

    clk_byte = 1'b1;
    sum_in   = 17'h000C0;
    @(negedge clk_bit);
    chk("lat1b_valid_low", 17'(y_valid), 17'd0);
    @(negedge clk_bit);
    chk("y_0x0C0", 17'(y_out), 17'h02);
    send_end();

    send_start(17'h1FF40);
    chk("y_neg192", 17'(y_out), 17'hFF);
    send_end();
    send_start(17'h1FFC0);
    chk("y_neg64_valid", 17'(y_valid), 17'd1);
    chk("y_neg64", 17'(y_out), 17'h00);
    send_end();
    send_start(17'h0FFFF);
`ifdef DA_OUT_SAT_EN
    chk("y_maxpos", 17'(y_out), 17'h7F);
`else
    chk("y_maxpos", 17'(y_out), 17'h00);
`endif
    send_end();
    send_start(17'h10000);
`ifdef DA_OUT_SAT_EN
    chk("y_maxneg", 17'(y_out), 17'h80);
`else
    chk("y_maxneg", 17'(y_out), 17'h00);
`endif
    send_end();
    chk("empty_after_stream", 17'(fifo_level), 17'd0);

    // Overflow: five samples into a depth-4 FIFO with no consumer.
    y_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send(17'(k * 128));
    chk("ovf_level", 17'(fifo_level), 17'd4);
    chk("ovf_set", 17'(ovf), 17'd1);
    chk("ovf_head_held", 17'(y_out), 17'h01);
    y_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_drain", 17'(y_out), 17'(k));
      @(negedge clk_bit);
    end
    chk("ovf_drained", 17'(y_valid), 17'd0);
    chk("ovf_sticky", 17'(ovf), 17'd1);
    clr_ovf = 1'b1;
    @(negedge clk_bit);
    clr_ovf = 1'b0;
    chk("ovf_cleared", 17'(ovf), 17'd0);

    // Full FIFO with a pop exactly in the push cycle.
    y_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(17'(k * 128));
    chk("full_level", 17'(fifo_level), 17'd4);
    clk_byte = 1'b1;
    sum_in   = 17'(5 * 128);
    @(negedge clk_bit);
    y_ready = 1'b1;
    @(negedge clk_bit);
    y_ready = 1'b0;
    chk("pp_level", 17'(fifo_level), 17'd4);
    chk("pp_no_ovf", 17'(ovf), 17'd0);
    chk("pp_head", 17'(y_out), 17'h02);
    send_end();
    y_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk("pp_drain", 17'(y_out), 17'(k));
      @(negedge clk_bit);
    end
    chk("pp_drained", 17'(y_valid), 17'd0);

    // Mid-stream reset with entries queued and the byte clock high.
    y_ready = 1'b0;
    for (int k = 7; k <= 9; k++) send(17'(k * 128));
    chk("pre_rst_level", 17'(fifo_level), 17'd3);
    clk_byte = 1'b1;
    sum_in   = 17'(10 * 128);
    rst_n    = 1'b0;
    #1;
    chk("rst_mid_valid", 17'(y_valid), 17'd0);
    chk("rst_mid_level", 17'(fifo_level), 17'd0);
    @(negedge clk_bit);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_bit);
    chk("no_false_capture_valid", 17'(y_valid), 17'd0);
    chk("no_false_capture_level", 17'(fifo_level), 17'd0);
    clk_byte = 1'b0;
    repeat (4) @(negedge clk_bit);
    send_start(17'(3 * 128));
    chk("post_rst_sample", 17'(y_out), 17'h03);
    chk("post_rst_level", 17'(fifo_level), 17'd1);
    send_end();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/da_out_round_fifo.md
DA_OUT_ROUND_FIFO -- requirements
Module: da_out_round_fifo

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the FIFO depth in samples (power of two, 2..16).
REQ-002 The module SHALL have port clk_bit  input  1  single block clock; the same bit clock that drives the DA filter.
REQ-003 The module SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 The module SHALL have port clk_byte  input  1  divided byte clock from the filter clock generator, sampled as data on clk_bit.
REQ-005 The module SHALL have port sum_in  input  17  signed DA filter output {intsum[9:0], extra[6:0]}, updated on the clk_byte rising edge.
REQ-006 The module SHALL have port y_out  output  8  signed rounded sample at the FIFO head.
REQ-007 The module SHALL have port y_valid  output  1  FIFO non-empty; y_out is valid.
REQ-008 The module SHALL have port y_ready  input  1  consumer accepts y_out when y_valid and y_ready are both high.
REQ-009 The module SHALL have port fifo_level  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-010 The module SHALL have port ovf  output  1  sticky flag: a sample was dropped.
REQ-011 The module SHALL have port clr_ovf  input  1  synchronous clear of ovf.

Function
REQ-012 The module SHALL register clk_byte into byte_q every clk_bit and detect a new sample when clk_byte=1 and byte_q=0 (the detect cycle).
REQ-013 In the detect cycle, the module SHALL capture sum_in into a stage register; sum_in is stable for 8 clk_bit cycles after the edge.
REQ-014 In the cycle after detect, the module SHALL round as r = sext18(stage)+64 and q = r[17:7], an 11-bit arithmetic shift with round-half-up.
REQ-015 In that same cycle, the module SHALL form the 8-bit result from q per REQ-026/027 and issue a push to the FIFO.
REQ-016 With the FIFO empty and no pop, y_valid SHALL rise 2 clk_bit cycles after the detect cycle.
REQ-017 Pop SHALL occur when y_valid and y_ready are both high; the head SHALL advance at that clock edge.
REQ-018 y_out SHALL be driven from the head entry combinationally and SHALL be held stable while y_valid is high and y_ready is low.
REQ-019 Read and write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full is defined as equal index bits with differing MSB.
REQ-020 A push with the FIFO full and no simultaneous pop SHALL drop the sample, leave FIFO contents unchanged, and set ovf.
REQ-021 A push and pop in the same cycle while full SHALL both be performed: fifo_level stays DEPTH and ovf is not set.
REQ-022 A push and pop in the same cycle while non-empty and not full SHALL leave fifo_level unchanged.
REQ-023 A pop when empty SHALL be impossible, since y_valid is low.
REQ-024 ovf SHALL hold until clr_ovf is high; if clr_ovf and a new overflow occur in the same cycle, ovf SHALL remain 1.

Reset
REQ-025 While rst_n is low, the module SHALL hold pointers=0, fifo_level=0, y_valid=0, y_out=0, ovf=0, stage=0, pending push=0 and byte_q=1; byte_q=1 suppresses a false capture when clk_byte is high at reset release. Asserting rst_n mid-stream SHALL discard any in-flight sample and all FIFO contents.

Configuration
REQ-026 With macro DA_OUT_SAT_EN defined, the result SHALL be q clamped to [-128,127]: 8'h7F if q>127, 8'h80 if q<-128, else q[7:0].
REQ-027 With DA_OUT_SAT_EN undefined, the result SHALL be q[7:0] (two's-complement wrap) and no clamp logic SHALL be present.

Verification
REQ-028 sum_in=17'h00080 then 17'h000C0 on successive clk_byte edges, y_ready=1 -> y_out 8'h01 then 8'h02, each y_valid 2 cycles after its detect cycle.
REQ-029 sum_in=17'h1FF40 (-192) -> y_out 8'hFF; sum_in=17'h1FFC0 (-64) -> y_out 8'h00 (half-up toward +inf).
REQ-030 sum_in=17'h0FFFF -> 8'h7F with DA_OUT_SAT_EN, 8'h00 without; sum_in=17'h10000 -> 8'h80 with, 8'h00 without.
REQ-031 y_ready=0, DEPTH=4, 5 samples 1..5 -> fifo_level=4, ovf=1; release y_ready -> outputs 1,2,3,4 in order, sample 5 lost; pulse clr_ovf -> ovf=0.
REQ-032 FIFO full and y_ready pulsed high exactly in the push cycle -> no ovf, fifo_level stays 4, order preserved.
REQ-033 rst_n pulsed low with 3 entries queued and clk_byte high -> y_valid=0, fifo_level=0 immediately; no capture until the next genuine clk_byte rising edge.
